// File: rtl/apb_fsm_controller_if.sv
// AHB-to-APB bridge control-stage bus bundle.
// master: the FSM controller (consumes the decoded AHB transfer, drives APB).
// slave : the surrounding pipeline and APB interface stage.
interface apb_fsm_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              Hwrite;
    logic              Hwritereg;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [DATA_W-1:0] Hwdata1;
    logic [DATA_W-1:0] Hwdata2;
    logic [2:0]        tempselx;
    logic              Pwrite;
    logic              Penable;
    logic [2:0]        Pselx;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Hreadyout;

    modport master (
        input  valid, Hwrite, Hwritereg, Haddr1, Haddr2, Hwdata1, Hwdata2, tempselx,
        output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout
    );

    modport slave (
        output valid, Hwrite, Hwritereg, Haddr1, Haddr2, Hwdata1, Hwdata2, tempselx,
        input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout
    );
endinterface

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control stage: sequences APB SETUP/ENABLE phases from the
// pipelined AHB transfer and stalls the AHB side via Hreadyout while APB
// phases are pending. All outputs are registered (Moore, loaded on entry).
// Optional macro BRIDGE_STATUS_EN adds fsm_state and xfer_count status ports.
module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    apb_fsm_controller_if.master bus
`ifdef BRIDGE_STATUS_EN
    ,
    output logic [2:0]           fsm_state,
    output logic [15:0]          xfer_count
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WWAIT    = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        WRITEP   = 3'd4,
        RENABLE  = 3'd5,
        WENABLE  = 3'd6,
        WENABLEP = 3'd7
    } state_t;

    state_t            state, nstate;
    logic              pwrite_q, penable_q, hready_q;
    logic [2:0]        pselx_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwrite_n, penable_n, hready_n;
    logic [2:0]        pselx_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n;

    // State and registered APB/AHB outputs; synchronous active-low reset.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state     <= IDLE;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            pselx_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hready_q  <= 1'b1;
        end else begin
            state     <= nstate;
            pwrite_q  <= pwrite_n;
            penable_q <= penable_n;
            pselx_q   <= pselx_n;
            paddr_q   <= paddr_n;
            pwdata_q  <= pwdata_n;
            hready_q  <= hready_n;
        end
    end

    // Next state plus the output values loaded on entry to that state.
    always_comb begin
        nstate    = state;
        pwrite_n  = pwrite_q;
        penable_n = penable_q;
        pselx_n   = pselx_q;
        paddr_n   = paddr_q;
        pwdata_n  = pwdata_q;
        hready_n  = hready_q;
        case (state)
            IDLE, RENABLE, WENABLE: begin
                if (!bus.valid) begin
                    nstate    = IDLE;
                    pselx_n   = '0;
                    penable_n = 1'b0;
                    hready_n  = 1'b1;
                end else if (bus.Hwrite) begin
                    nstate    = WWAIT;
                    pselx_n   = '0;
                    penable_n = 1'b0;
                    hready_n  = 1'b1;
                end else begin
                    nstate    = READ;
                    paddr_n   = bus.Haddr1;
                    pwrite_n  = 1'b0;
                    pselx_n   = bus.tempselx;
                    penable_n = 1'b0;
                    hready_n  = 1'b0;
                end
            end
            WWAIT: begin
                nstate    = bus.valid ? WRITEP : WRITE;
                paddr_n   = bus.Haddr1;
                pwdata_n  = bus.Hwdata1;
                pwrite_n  = 1'b1;
                pselx_n   = bus.tempselx;
                penable_n = 1'b0;
                hready_n  = !bus.valid;
            end
            READ: begin
                nstate    = RENABLE;
                penable_n = 1'b1;
                hready_n  = 1'b1;
            end
            WRITE: begin
                nstate    = bus.valid ? WENABLEP : WENABLE;
                penable_n = 1'b1;
                hready_n  = !bus.valid;
            end
            WRITEP: begin
                nstate    = WENABLEP;
                penable_n = 1'b1;
                hready_n  = 1'b0;
            end
            WENABLEP: begin
                // The pending transfer is two stages back, hence Haddr2/Hwdata2.
                paddr_n   = bus.Haddr2;
                pselx_n   = bus.tempselx;
                penable_n = 1'b0;
                if (!bus.Hwritereg) begin
                    nstate   = READ;
                    pwrite_n = 1'b0;
                    hready_n = 1'b0;
                end else begin
                    nstate   = bus.valid ? WRITEP : WRITE;
                    pwdata_n = bus.Hwdata2;
                    pwrite_n = 1'b1;
                    hready_n = !bus.valid;
                end
            end
            default: begin
                nstate    = IDLE;
                pwrite_n  = 1'b0;
                penable_n = 1'b0;
                pselx_n   = '0;
                paddr_n   = '0;
                pwdata_n  = '0;
                hready_n  = 1'b1;
            end
        endcase
    end

    assign bus.Pwrite    = pwrite_q;
    assign bus.Penable   = penable_q;
    assign bus.Pselx     = pselx_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Hreadyout = hready_q;

`ifdef BRIDGE_STATUS_EN
    assign fsm_state = state;

    // Count ENABLE-phase cycles; wraps naturally at 16 bits.
    always_ff @(posedge Hclk) begin
        if (!Hresetn)
            xfer_count <= '0;
        else if (penable_q)
            xfer_count <= xfer_count + 16'd1;
    end
`endif

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- Bridge control stage. Consumes the pipelined, decoded AHB transfer and sequences APB SETUP/ENABLE phases.
- Its Pwrite/Pselx/Penable/Paddr/Pwdata outputs drive the APB controller interface stage directly.
- Drives Hreadyout back to the AHB slave interface to stall the AHB side while APB phases are pending.
- Supports single read, single write, and back-to-back pipelined writes.

Parameters:
- ADDR_W, 32, width of Haddr1/Haddr2/Paddr
- DATA_W, 32, width of Hwdata1/Hwdata2/Pwdata

Ports:
- Hclk  input  1  bridge clock; all state and outputs update on its rising edge
- Hresetn  input  1  synchronous active-low reset, sampled on the Hclk rising edge
- valid  input  1  current AHB address phase is a valid NONSEQ/SEQ transfer to the bridge
- Hwrite  input  1  write flag of the current address phase
- Hwritereg  input  1  Hwrite registered one cycle
- Haddr1  input  ADDR_W  address registered one cycle
- Haddr2  input  ADDR_W  address registered two cycles
- Hwdata1  input  DATA_W  write data registered one cycle
- Hwdata2  input  DATA_W  write data registered two cycles
- tempselx  input  3  one-hot slave select decoded from the address
- Pwrite  output  1  APB write
- Penable  output  1  APB enable
- Pselx  output  3  APB select
- Paddr  output  ADDR_W  APB address
- Pwdata  output  DATA_W  APB write data
- Hreadyout  output  1  AHB ready; 0 stalls the AHB master

Behaviour:
- Reset (Hresetn=0 at the edge): state=IDLE; Pwrite=0, Penable=0, Pselx=0, Paddr=0, Pwdata=0, Hreadyout=1.
- Reset mid-transfer aborts immediately. No partial APB phase survives.
- All outputs are registered and loaded on the transition into the next state (Moore, one cycle latency from the decision).
- State transitions:
  - IDLE: ~valid -> IDLE; valid&Hwrite -> WWAIT; valid&~Hwrite -> READ.
  - WWAIT: ~valid -> WRITE; valid -> WRITEP.
  - READ -> RENABLE (unconditional).
  - WRITE: ~valid -> WENABLE; valid -> WENABLEP.
  - WRITEP -> WENABLEP (unconditional).
  - RENABLE and WENABLE: ~valid -> IDLE; valid&~Hwrite -> READ; valid&Hwrite -> WWAIT.
  - WENABLEP: ~Hwritereg -> READ; Hwritereg&~valid -> WRITE; Hwritereg&valid -> WRITEP.
- Output loads per target state:
  - READ: Paddr=Haddr1 (Haddr2 when coming from WENABLEP), Pwrite=0, Pselx=tempselx, Penable=0, Hreadyout=0.
  - WRITE/WRITEP from WWAIT: Paddr=Haddr1, Pwdata=Hwdata1. From WENABLEP: Paddr=Haddr2, Pwdata=Hwdata2. In all cases Pwrite=1, Pselx=tempselx, Penable=0. Hreadyout=1 for WRITE, 0 for WRITEP.
  - RENABLE/WENABLE: Penable=1, Hreadyout=1; Paddr, Pwdata, Pselx, Pwrite held.
  - WENABLEP: Penable=1, Hreadyout=0 (a pending write exists); others held.
  - IDLE from an ENABLE state: Pselx=0, Penable=0, Hreadyout=1; Paddr/Pwdata held.
  - WWAIT: Penable=0, Pselx=0, Hreadyout=1.
- Invariants:
  - Penable=1 only in the cycle directly after a SETUP cycle with the same Pselx and Paddr.
  - Pselx is never 0 while Penable=1.
- Every APB transfer is exactly 2 cycles; no Pready wait states.
- Unused state encodings go to IDLE with reset output values.

Optional Feature:
- Macro: BRIDGE_STATUS_EN.
- Defined: adds output fsm_state [2:0] (current state encoding, IDLE=0) and output xfer_count [15:0].
  - xfer_count increments by 1 on every cycle with Penable=1, wraps 0xFFFF->0, and resets to 0.
- Undefined: neither port exists; behaviour otherwise identical.

Test Plan:
- Reset: Hresetn=0 for 2 cycles with valid=1 -> all outputs at reset values, Hreadyout=1, state IDLE.
- Single read: valid=1, Hwrite=0, Haddr1=0x8000_0010, tempselx=3'b001 for 1 cycle ->
  - next cycle: Pselx=001, Paddr=0x8000_0010, Pwrite=0, Penable=0, Hreadyout=0;
  - following cycle: Penable=1, Hreadyout=1;
  - then IDLE with Pselx=0.
- Single write: valid=1, Hwrite=1 then valid=0, Haddr1=0x8400_0004, Hwdata1=0xDEAD_BEEF ->
  - states IDLE->WWAIT->WRITE->WENABLE->IDLE;
  - Pwdata=0xDEAD_BEEF, Pwrite=1 during SETUP and ENABLE.
- Back-to-back writes: valid held 1, Hwrite=1, addresses 0x8000_0000 and 0x8000_0004 ->
  - path WWAIT->WRITEP->WENABLEP->WRITE->WENABLE;
  - second SETUP drives Paddr=Haddr2=0x8000_0004;
  - Hreadyout=0 in WRITEP/WENABLEP.
- Write followed by read: after WENABLEP with Hwritereg=0 -> READ with Paddr=Haddr2, Pwrite=0.
- Reset mid-transfer: assert Hresetn=0 in RENABLE -> next edge Penable=0, Pselx=0, Hreadyout=1, state IDLE.
